// File: rtl/agu_pkg.sv
// Shared encodings and lane helpers for the cirno9 address-generation stage.
package agu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OP_W   = 4;

  // Op field layout: bit3 store, bit2 unsigned load, bits1:0 access size
  localparam int unsigned OP_STORE_BIT = 3;
  localparam int unsigned OP_UNS_BIT   = 2;

  localparam logic [1:0] LS_SZ_B = 2'b00;
  localparam logic [1:0] LS_SZ_H = 2'b01;
  localparam logic [1:0] LS_SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } agu_state_e;

  // Unaligned half/word or the reserved size code
  function automatic logic ls_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      LS_SZ_B: ls_misaligned = 1'b0;
      LS_SZ_H: ls_misaligned = off[0];
      LS_SZ_W: ls_misaligned = (off != 2'b00);
      default: ls_misaligned = 1'b1;
    endcase
  endfunction

  // Byte write enables for an aligned store
  function automatic logic [3:0] ls_wen(input logic [1:0] size, input logic [1:0] off);
    case (size)
      LS_SZ_B: ls_wen = 4'b0001 << off;
      LS_SZ_H: ls_wen = 4'b0011 << off;
      default: ls_wen = 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane the access could hit
  function automatic logic [XLEN-1:0] ls_wdat(input logic [1:0] size, input logic [XLEN-1:0] rs2);
    case (size)
      LS_SZ_B: ls_wdat = {4{rs2[7:0]}};
      LS_SZ_H: ls_wdat = {2{rs2[15:0]}};
      default: ls_wdat = rs2;
    endcase
  endfunction

endpackage

// File: rtl/agu_ld_align.sv
// Load-return extractor: shifts the addressed lane down and extends it.
module agu_ld_align
  import agu_pkg::*;
(
  input  logic [XLEN-1:0] i_rdat,
  input  logic [1:0]      i_off,
  input  logic [1:0]      i_size,
  input  logic            i_uns,
  output logic [XLEN-1:0] o_dat
);

  logic [XLEN-1:0] sh;

  // Select the byte/half lane and sign- or zero-extend it
  always_comb begin
    sh = i_rdat >> {i_off, 3'b000};
    case (i_size)
      LS_SZ_B: o_dat = i_uns ? {24'd0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
      LS_SZ_H: o_dat = i_uns ? {16'd0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
      default: o_dat = i_rdat;
    endcase
  end

endmodule

// File: rtl/agu.sv
// Address generation, lsu request issue and load writeback for cirno9.
module agu
  import agu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hs_ex4ag_val,
  output logic              hs_ag4ex_rdy,
  input  logic [XLEN-1:0]   i_ex_rs1,
  input  logic [XLEN-1:0]   i_ex_imm,
  input  logic [XLEN-1:0]   i_ex_rs2,
  input  logic [OP_W-1:0]   i_ex_op,
  input  logic [REG_AW-1:0] i_ex_rd,
  output logic              hs_ag4ls_val,
  input  logic              hs_ls4ag_rdy,
  output logic [XLEN-1:0]   o_ag_adr,
  output logic [XLEN-1:0]   o_ag_wdat,
  output logic [3:0]        o_ag_wen,
  output logic              o_ag_ren,
  input  logic              i_ls_rvld,
  input  logic [XLEN-1:0]   i_rdat,
  output logic              o_wb_val,
  output logic [REG_AW-1:0] o_wb_rd,
  output logic [XLEN-1:0]   o_wb_dat,
  output logic              o_exc_misalign,
  output logic [XLEN-1:0]   o_exc_adr
);

  agu_state_e        state;
  logic [XLEN-1:0]   adr_q;
  logic [OP_W-1:0]   op_q;
  logic [REG_AW-1:0] rd_q;

  logic [XLEN-1:0]   ex_adr;
  logic              ex_mis;
  logic              ex_store;
  logic [XLEN-1:0]   ld_dat;

  // Decode the op presented by EX
  always_comb begin
    ex_adr   = i_ex_rs1 + i_ex_imm;
    ex_mis   = ls_misaligned(i_ex_op[1:0], ex_adr[1:0]);
    ex_store = i_ex_op[OP_STORE_BIT];
  end

  assign o_ag_adr = {adr_q[XLEN-1:2], 2'b00};

  agu_ld_align u_ld_align (
    .i_rdat (i_rdat),
    .i_off  (adr_q[1:0]),
    .i_size (op_q[1:0]),
    .i_uns  (op_q[OP_UNS_BIT]),
    .o_dat  (ld_dat)
  );

  // Control FSM with request, writeback and exception registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      hs_ag4ex_rdy   <= 1'b1;
      hs_ag4ls_val   <= 1'b0;
      adr_q          <= '0;
      op_q           <= '0;
      rd_q           <= '0;
      o_ag_wdat      <= '0;
      o_ag_wen       <= '0;
      o_ag_ren       <= 1'b0;
      o_wb_val       <= 1'b0;
      o_wb_rd        <= '0;
      o_wb_dat       <= '0;
      o_exc_misalign <= 1'b0;
      o_exc_adr      <= '0;
    end else begin
      o_wb_val       <= 1'b0;
      o_exc_misalign <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hs_ex4ag_val) begin
            if (ex_mis) begin
              o_exc_misalign <= 1'b1;
              o_exc_adr      <= ex_adr;
            end else begin
              state        <= ST_REQ;
              hs_ag4ex_rdy <= 1'b0;
              hs_ag4ls_val <= 1'b1;
              adr_q        <= ex_adr;
              op_q         <= i_ex_op;
              rd_q         <= i_ex_rd;
              o_ag_wdat    <= ex_store ? ls_wdat(i_ex_op[1:0], i_ex_rs2) : '0;
              o_ag_wen     <= ex_store ? ls_wen(i_ex_op[1:0], ex_adr[1:0]) : 4'b0000;
              o_ag_ren     <= !ex_store;
            end
          end
        end
        ST_REQ: begin
          if (hs_ls4ag_rdy) begin
            hs_ag4ls_val <= 1'b0;
            o_ag_wdat    <= '0;
            o_ag_wen     <= '0;
            o_ag_ren     <= 1'b0;
            if (op_q[OP_STORE_BIT]) begin
              state        <= ST_IDLE;
              hs_ag4ex_rdy <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (i_ls_rvld) begin
            state        <= ST_IDLE;
            hs_ag4ex_rdy <= 1'b1;
            o_wb_val     <= 1'b1;
            o_wb_rd      <= rd_q;
            o_wb_dat     <= ld_dat;
          end
        end
        default: begin
          state        <= ST_IDLE;
          hs_ag4ex_rdy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_agu.sv
// Self-checking bench for agu against a byte-arithmetic reference model.
module tb_agu;

  logic        clk = 1'b0;
  logic        rst;
  logic        hs_ex4ag_val;
  logic        hs_ag4ex_rdy;
  logic [31:0] i_ex_rs1, i_ex_imm, i_ex_rs2;
  logic [3:0]  i_ex_op;
  logic [4:0]  i_ex_rd;
  logic        hs_ag4ls_val;
  logic        hs_ls4ag_rdy;
  logic [31:0] o_ag_adr, o_ag_wdat;
  logic [3:0]  o_ag_wen;
  logic        o_ag_ren;
  logic        i_ls_rvld;
  logic [31:0] i_rdat;
  logic        o_wb_val;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_dat;
  logic        o_exc_misalign;
  logic [31:0] o_exc_adr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  agu dut (
    .clk(clk), .rst(rst),
    .hs_ex4ag_val(hs_ex4ag_val), .hs_ag4ex_rdy(hs_ag4ex_rdy),
    .i_ex_rs1(i_ex_rs1), .i_ex_imm(i_ex_imm), .i_ex_rs2(i_ex_rs2),
    .i_ex_op(i_ex_op), .i_ex_rd(i_ex_rd),
    .hs_ag4ls_val(hs_ag4ls_val), .hs_ls4ag_rdy(hs_ls4ag_rdy),
    .o_ag_adr(o_ag_adr), .o_ag_wdat(o_ag_wdat), .o_ag_wen(o_ag_wen), .o_ag_ren(o_ag_ren),
    .i_ls_rvld(i_ls_rvld), .i_rdat(i_rdat),
    .o_wb_val(o_wb_val), .o_wb_rd(o_wb_rd), .o_wb_dat(o_wb_dat),
    .o_exc_misalign(o_exc_misalign), .o_exc_adr(o_exc_adr)
  );

  // ---------------- reference model ----------------
  function automatic int m_bytes(input logic [3:0] op);
    case (op[1:0])
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_mis(input logic [3:0] op, input logic [31:0] adr);
    int n = m_bytes(op);
    if (n == 0) return 1'b1;
    return (adr % n) != 0;
  endfunction

  function automatic logic [3:0] m_wen(input logic [3:0] op, input logic [31:0] adr);
    int n = m_bytes(op);
    if (!op[3]) return 4'd0;
    return 4'(((1 << n) - 1) << (adr % 4));
  endfunction

  function automatic logic [31:0] m_wdat(input logic [3:0] op, input logic [31:0] rs2);
    int n = m_bytes(op);
    if (!op[3]) return 32'd0;
    if (n == 1) return (rs2 % 256) * 32'h0101_0101;
    if (n == 2) return (rs2 % 65536) * 32'h0001_0001;
    return rs2;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] adr,
                                         input logic [31:0] rdat);
    int n = m_bytes(op);
    longint v;
    longint span;
    if (n == 4) return rdat;
    span = longint'(1) << (8 * n);
    v = longint'(rdat / (32'd1 << (8 * (adr % 4)))) % span;
    if (!op[2] && v >= span / 2) v = v - span + (longint'(1) << 32);
    return 32'(v);
  endfunction

  // ---------------- transaction driver (observes, does not judge) ----------------
  logic        obs_exc, obs_exc_after, obs_val, obs_val_after, obs_stable, obs_rdy_req;
  logic        obs_idle, obs_wbv_early, obs_wbv, obs_wbv_after, obs_rdy_wb, obs_ren;
  logic [31:0] obs_exc_adr, obs_adr, obs_wdat, obs_wb_dat;
  logic [3:0]  obs_wen;
  logic [4:0]  obs_wb_rd;

  task automatic run_op(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] imm,
                        input logic [31:0] rs2, input logic [4:0] rd, input logic [31:0] rdat,
                        input int rdy_dly, input int rvld_dly);
    int n = 0;
    while (hs_ag4ex_rdy !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n == 20) begin
      total++; bad++;
      $display("FAIL ready_timeout: hs_ag4ex_rdy=%b required 1 within 20 cycles", hs_ag4ex_rdy);
    end
    hs_ex4ag_val = 1'b1; i_ex_op = op; i_ex_rs1 = rs1; i_ex_imm = imm;
    i_ex_rs2 = rs2; i_ex_rd = rd;
    @(posedge clk); #1;
    hs_ex4ag_val = 1'b0; i_ex_rs1 = $urandom; i_ex_imm = $urandom; i_ex_rs2 = $urandom;
    obs_exc = o_exc_misalign; obs_exc_adr = o_exc_adr; obs_val = hs_ag4ls_val;
    obs_wbv_early = 1'b0; obs_wbv = 1'b0;
    if (obs_val !== 1'b1) begin
      @(posedge clk); #1;
      obs_exc_after = o_exc_misalign;
      obs_val = obs_val | hs_ag4ls_val;
      obs_idle = hs_ag4ex_rdy;
      return;
    end
    obs_adr = o_ag_adr; obs_wen = o_ag_wen; obs_wdat = o_ag_wdat; obs_ren = o_ag_ren;
    obs_stable = 1'b1; obs_rdy_req = hs_ag4ex_rdy;
    repeat (rdy_dly) begin
      @(posedge clk); #1;
      if (hs_ag4ls_val !== 1'b1 || o_ag_adr !== obs_adr || o_ag_wen !== obs_wen ||
          o_ag_wdat !== obs_wdat || o_ag_ren !== obs_ren) obs_stable = 1'b0;
      obs_rdy_req = obs_rdy_req | hs_ag4ex_rdy;
    end
    hs_ls4ag_rdy = 1'b1;
    @(posedge clk); #1;
    hs_ls4ag_rdy = 1'b0;
    obs_idle = hs_ag4ex_rdy; obs_val_after = hs_ag4ls_val;
    if (op[3]) return;
    repeat (rvld_dly) begin
      obs_wbv_early = obs_wbv_early | o_wb_val | hs_ag4ex_rdy;
      @(posedge clk); #1;
    end
    i_ls_rvld = 1'b1; i_rdat = rdat;
    @(posedge clk); #1;
    i_ls_rvld = 1'b0; i_rdat = $urandom;
    obs_wbv = o_wb_val; obs_wb_dat = o_wb_dat; obs_wb_rd = o_wb_rd; obs_rdy_wb = hs_ag4ex_rdy;
    @(posedge clk); #1;
    obs_wbv_after = o_wb_val;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1; hs_ex4ag_val = 1'b0; hs_ls4ag_rdy = 1'b0; i_ls_rvld = 1'b0;
    i_ex_rs1 = 0; i_ex_imm = 0; i_ex_rs2 = 0; i_ex_op = 0; i_ex_rd = 0; i_rdat = 0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    total++;
    if (hs_ag4ex_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %b want 1", hs_ag4ex_rdy); end
    total++;
    if ({hs_ag4ls_val, o_wb_val, o_exc_misalign, o_ag_ren} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {hs_ag4ls_val, o_wb_val, o_exc_misalign, o_ag_ren});
    end
    total++;
    if ({o_ag_adr, o_ag_wdat, o_ag_wen, o_wb_dat, o_exc_adr, o_wb_rd} !== '0) begin
      bad++; $display("FAIL reset_data: adr=%h wdat=%h wen=%b want all 0", o_ag_adr, o_ag_wdat, o_ag_wen);
    end
  endtask

  task automatic test_store_byte;
    run_op(4'b1000, 32'h8000_0000, 32'd3, 32'h1234_56AB, 5'd0, 32'd0, 0, 0);
    total++;
    if (obs_val !== 1'b1 || obs_adr !== 32'h8000_0000) begin
      bad++; $display("FAIL store_byte_adr: val=%b adr=%h want 1 80000000", obs_val, obs_adr);
    end
    total++;
    if (obs_wen !== 4'b1000 || obs_wdat !== 32'hABAB_ABAB || obs_ren !== 1'b0) begin
      bad++; $display("FAIL store_byte_lanes: wen=%b wdat=%h ren=%b want 1000 abababab 0", obs_wen, obs_wdat, obs_ren);
    end
    total++;
    if (obs_idle !== 1'b1 || obs_val_after !== 1'b0) begin
      bad++; $display("FAIL store_byte_idle: rdy=%b val=%b want 1 0", obs_idle, obs_val_after);
    end
  endtask

  task automatic test_load_half;
    run_op(4'b0001, 32'h8000_0000, 32'd6, 32'd0, 5'd17, 32'h8001_7FFF, 0, 2);
    total++;
    if (obs_wbv !== 1'b1 || obs_wb_dat !== 32'hFFFF_8001 || obs_wb_rd !== 5'd17) begin
      bad++; $display("FAIL load_half_signed: v=%b dat=%h rd=%0d want 1 ffff8001 17", obs_wbv, obs_wb_dat, obs_wb_rd);
    end
    total++;
    if (obs_ren !== 1'b1 || obs_wen !== 4'd0 || obs_adr !== 32'h8000_0004) begin
      bad++; $display("FAIL load_half_req: ren=%b wen=%b adr=%h want 1 0000 80000004", obs_ren, obs_wen, obs_adr);
    end
    run_op(4'b0101, 32'h8000_0000, 32'd6, 32'd0, 5'd3, 32'h8001_7FFF, 0, 0);
    total++;
    if (obs_wbv !== 1'b1 || obs_wb_dat !== 32'h0000_8001 || obs_wb_rd !== 5'd3) begin
      bad++; $display("FAIL load_half_unsigned: v=%b dat=%h rd=%0d want 1 00008001 3", obs_wbv, obs_wb_dat, obs_wb_rd);
    end
    total++;
    if (obs_wbv_after !== 1'b0 || obs_rdy_wb !== 1'b1) begin
      bad++; $display("FAIL load_wb_pulse: after=%b rdy=%b want 0 1", obs_wbv_after, obs_rdy_wb);
    end
  endtask

  task automatic test_misaligned;
    run_op(4'b0010, 32'h8000_0000, 32'd2, 32'd0, 5'd1, 32'd0, 0, 0);
    total++;
    if (obs_exc !== 1'b1 || obs_exc_adr !== 32'h8000_0002) begin
      bad++; $display("FAIL misalign_exc: exc=%b adr=%h want 1 80000002", obs_exc, obs_exc_adr);
    end
    total++;
    if (obs_val !== 1'b0 || obs_exc_after !== 1'b0 || obs_idle !== 1'b1) begin
      bad++; $display("FAIL misalign_quiet: val=%b exc_next=%b rdy=%b want 0 0 1", obs_val, obs_exc_after, obs_idle);
    end
  endtask

  task automatic test_stall;
    run_op(4'b1001, 32'h0000_1000, 32'd2, 32'h0000_BEEF, 5'd0, 32'd0, 5, 0);
    total++;
    if (obs_stable !== 1'b1 || obs_rdy_req !== 1'b0) begin
      bad++; $display("FAIL stall_stable: stable=%b rdy=%b want 1 0", obs_stable, obs_rdy_req);
    end
    total++;
    if (obs_wen !== 4'b1100 || obs_wdat !== 32'hBEEF_BEEF || obs_idle !== 1'b1) begin
      bad++; $display("FAIL stall_issue: wen=%b wdat=%h rdy=%b want 1100 beefbeef 1", obs_wen, obs_wdat, obs_idle);
    end
  endtask

  task automatic test_wrap;
    run_op(4'b0010, 32'hFFFF_FFFC, 32'd8, 32'd0, 5'd9, 32'hCAFE_F00D, 0, 1);
    total++;
    if (obs_adr !== 32'h0000_0004 || obs_wb_dat !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL addr_wrap: adr=%h dat=%h want 00000004 cafef00d", obs_adr, obs_wb_dat);
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    // reset while a request is pending in REQ
    hs_ex4ag_val = 1'b1; i_ex_op = 4'b0010; i_ex_rs1 = 32'h100; i_ex_imm = 0; i_ex_rd = 5'd4;
    @(posedge clk); #1; hs_ex4ag_val = 1'b0;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    total++;
    if (hs_ag4ls_val !== 1'b0 || hs_ag4ex_rdy !== 1'b1) begin
      bad++; $display("FAIL reset_in_req: val=%b rdy=%b want 0 1", hs_ag4ls_val, hs_ag4ex_rdy);
    end
    // reset while waiting for load data, then a late data return
    hs_ex4ag_val = 1'b1;
    @(posedge clk); #1; hs_ex4ag_val = 1'b0; hs_ls4ag_rdy = 1'b1;
    @(posedge clk); #1; hs_ls4ag_rdy = 1'b0;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    i_ls_rvld = 1'b1; i_rdat = 32'h1234_5678;
    @(posedge clk); #1; i_ls_rvld = 1'b0;
    seen = o_wb_val;
    @(posedge clk); #1; seen = seen | o_wb_val;
    total++;
    if (seen !== 1'b0 || hs_ag4ex_rdy !== 1'b1) begin
      bad++; $display("FAIL reset_in_wait: wb_val=%b rdy=%b want 0 1", seen, hs_ag4ex_rdy);
    end
  endtask

  task automatic test_rvld_idle;
    logic seen;
    i_ls_rvld = 1'b1; i_rdat = 32'hDEAD_BEEF;
    @(posedge clk); #1; i_ls_rvld = 1'b0;
    seen = o_wb_val;
    total++;
    if (seen !== 1'b0 || hs_ag4ex_rdy !== 1'b1) begin
      bad++; $display("FAIL rvld_in_idle: wb_val=%b rdy=%b want 0 1", seen, hs_ag4ex_rdy);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  op;
      logic [31:0] rs1, imm, rs2, rdat, adr;
      logic [4:0]  rd;
      int          rdy_dly, rvld_dly;
      op   = 4'($urandom);
      rs1  = $urandom;
      imm  = 32'($signed(12'($urandom)));
      rs2  = $urandom;
      rdat = $urandom;
      rd   = 5'($urandom);
      rdy_dly  = $urandom_range(0, 3);
      rvld_dly = $urandom_range(0, 3);
      adr  = rs1 + imm;
      run_op(op, rs1, imm, rs2, rd, rdat, rdy_dly, rvld_dly);
      total++;
      if (obs_exc !== m_mis(op, adr)) begin
        bad++; $display("FAIL rand_exc[%0d]: exc=%b want %b op=%b adr=%h", i, obs_exc, m_mis(op, adr), op, adr);
      end
      if (m_mis(op, adr)) begin
        total++;
        if (obs_exc_adr !== adr || obs_val !== 1'b0) begin
          bad++; $display("FAIL rand_exc_adr[%0d]: adr=%h val=%b want %h 0", i, obs_exc_adr, obs_val, adr);
        end
      end else begin
        total++;
        if (obs_adr !== (adr & 32'hFFFF_FFFC) || obs_wen !== m_wen(op, adr) ||
            obs_wdat !== m_wdat(op, rs2) || obs_ren !== !op[3] || obs_stable !== 1'b1) begin
          bad++; $display("FAIL rand_req[%0d]: adr=%h wen=%b wdat=%h ren=%b want %h %b %h %b", i,
                          obs_adr, obs_wen, obs_wdat, obs_ren, adr & 32'hFFFF_FFFC,
                          m_wen(op, adr), m_wdat(op, rs2), !op[3]);
        end
        if (!op[3]) begin
          total++;
          if (obs_wbv !== 1'b1 || obs_wbv_early !== 1'b0 || obs_wb_dat !== m_load(op, adr, rdat) ||
              obs_wb_rd !== rd || obs_wbv_after !== 1'b0) begin
            bad++; $display("FAIL rand_load[%0d]: v=%b early=%b dat=%h rd=%0d want 1 0 %h %0d", i,
                            obs_wbv, obs_wbv_early, obs_wb_dat, obs_wb_rd, m_load(op, adr, rdat), rd);
          end
        end else begin
          total++;
          if (obs_idle !== 1'b1) begin
            bad++; $display("FAIL rand_store_idle[%0d]: rdy=%b want 1", i, obs_idle);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_store_byte;
    test_load_half;
    test_misaligned;
    test_stall;
    test_wrap;
    test_reset_mid;
    test_rvld_idle;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
